// File: rtl/fp_compare_pipe_if.sv
// Operation/result handshake bundle for fp_compare_pipe.
// The master drives operations and consumes results; the slave is the comparator.
interface fp_compare_pipe_if #(
  parameter int FPWID = 32,
  parameter int TAGW  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [FPWID-1:0] a;
  logic [FPWID-1:0] b;
  logic [TAGW-1:0]  tag_i;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      o;
  logic [FPWID-1:0] res;
  logic [TAGW-1:0]  tag_o;
  logic             nan;
  logic             snan;
  logic [1:0]       flags;
  logic             clr_flags;

  modport master (
    output in_valid, op, a, b, tag_i, out_ready, clr_flags,
    input  in_ready, out_valid, o, res, tag_o, nan, snan, flags
  );

  modport slave (
    input  in_valid, op, a, b, tag_i, out_ready, clr_flags,
    output in_ready, out_valid, o, res, tag_o, nan, snan, flags
  );
endinterface

// File: rtl/fp_compare_pipe.sv
// Two-stage pipelined IEEE 754 comparator: S1 decodes and compares magnitudes,
// S2 forms the predicate mask and the min/max result, with sticky exception flags.
module fp_compare_pipe #(
  parameter int FPWID = 32,
  parameter int TAGW  = 4
) (
  input logic              clk,
  input logic              rst,
  fp_compare_pipe_if.slave bus
);
  localparam int EW = (FPWID == 16)  ? 5  :
                      (FPWID == 64)  ? 11 :
                      (FPWID == 128) ? 15 : 8;
  localparam int FW = FPWID - 1 - EW;
  localparam logic [FPWID-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_CMP = 2'd0,
    OP_MIN = 2'd1,
    OP_MAX = 2'd2,
    OP_RSV = 2'd3
  } op_e;

  logic [EW-1:0] a_exp, b_exp;
  logic [FW-1:0] a_frac, b_frac;
  logic          a_nan, b_nan, a_snan, b_snan, a_zero, b_zero;
  logic          mag_lt, mag_eq;

  assign a_exp  = bus.a[FPWID-2 -: EW];
  assign b_exp  = bus.b[FPWID-2 -: EW];
  assign a_frac = bus.a[FW-1:0];
  assign b_frac = bus.b[FW-1:0];
  assign a_nan  = (&a_exp) && (|a_frac);
  assign b_nan  = (&b_exp) && (|b_frac);
  assign a_snan = a_nan && !a_frac[FW-1];
  assign b_snan = b_nan && !b_frac[FW-1];
  assign a_zero = ~|bus.a[FPWID-2:0];
  assign b_zero = ~|bus.b[FPWID-2:0];
  assign mag_lt = bus.a[FPWID-2:0] <  bus.b[FPWID-2:0];
  assign mag_eq = bus.a[FPWID-2:0] == bus.b[FPWID-2:0];

  logic             s1_valid;
  op_e              s1_op;
  logic [TAGW-1:0]  s1_tag;
  logic [FPWID-1:0] s1_a, s1_b;
  logic             s1_a_nan, s1_b_nan, s1_a_snan, s1_b_snan;
  logic             s1_mag_lt, s1_mag_eq, s1_both_zero;

  logic             s2_valid;
  logic [15:0]      s2_o;
  logic [FPWID-1:0] s2_res;
  logic [TAGW-1:0]  s2_tag;
  logic             s2_nan, s2_snan;
  logic [1:0]       flags_q;

  logic advance;
  assign advance      = !s2_valid || bus.out_ready;
  assign bus.in_ready = advance || !s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_op        <= OP_CMP;
      s1_tag       <= '0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_a_nan     <= 1'b0;
      s1_b_nan     <= 1'b0;
      s1_a_snan    <= 1'b0;
      s1_b_snan    <= 1'b0;
      s1_mag_lt    <= 1'b0;
      s1_mag_eq    <= 1'b0;
      s1_both_zero <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid     <= bus.in_valid;
      s1_op        <= op_e'(bus.op);
      s1_tag       <= bus.tag_i;
      s1_a         <= bus.a;
      s1_b         <= bus.b;
      s1_a_nan     <= a_nan;
      s1_b_nan     <= b_nan;
      s1_a_snan    <= a_snan;
      s1_b_snan    <= b_snan;
      s1_mag_lt    <= mag_lt;
      s1_mag_eq    <= mag_eq;
      s1_both_zero <= a_zero && b_zero;
    end
  end

  // IEEE predicates treat +0 == -0, but min/max order -0 below +0 (a_less).
  logic sign_a, sign_b, unord, mag_gt, eq_c, lt_c, le_c, a_less;
  logic [15:0]      mask_c;
  logic [FPWID-1:0] nan_res, res_c;

  assign sign_a = s1_a[FPWID-1];
  assign sign_b = s1_b[FPWID-1];
  assign unord  = s1_a_nan || s1_b_nan;
  assign mag_gt = !s1_mag_lt && !s1_mag_eq;
  assign eq_c   = !unord && (s1_both_zero || (s1_mag_eq && (sign_a == sign_b)));
  assign lt_c   = !unord && ((sign_a != sign_b) ? (sign_a && !s1_both_zero)
                                                : (sign_a ? mag_gt : s1_mag_lt));
  assign le_c   = lt_c || eq_c;
  assign a_less = (sign_a != sign_b) ? sign_a : (sign_a ? mag_gt : s1_mag_lt);

  assign mask_c = {3'b000, !unord, !s1_mag_lt, !le_c, !lt_c, !eq_c,
                   3'b000,  unord,  s1_mag_lt,  le_c,  lt_c,  eq_c};

  assign nan_res = (s1_a_nan && s1_b_nan) ? QNAN : (s1_a_nan ? s1_b : s1_a);

  always_comb begin
    res_c = '0;
    case (s1_op)
      OP_MIN:  res_c = unord ? nan_res : (a_less ? s1_a : s1_b);
      OP_MAX:  res_c = unord ? nan_res : (a_less ? s1_b : s1_a);
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_o     <= '0;
      s2_res   <= '0;
      s2_tag   <= '0;
      s2_nan   <= 1'b0;
      s2_snan  <= 1'b0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_o     <= mask_c;
      s2_res   <= res_c;
      s2_tag   <= s1_tag;
      s2_nan   <= unord;
      s2_snan  <= s1_a_snan || s1_b_snan;
    end
  end

  // A clear arriving with a result handshake still keeps that result's contribution.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 2'b00;
    end else if (s2_valid && bus.out_ready) begin
      flags_q <= (bus.clr_flags ? 2'b00 : flags_q) | {s2_snan, s2_nan};
    end else if (bus.clr_flags) begin
      flags_q <= 2'b00;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.o         = s2_o;
  assign bus.res       = s2_res;
  assign bus.tag_o     = s2_tag;
  assign bus.nan       = s2_nan;
  assign bus.snan      = s2_snan;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed bench for fp_compare_pipe: single and double precision instances sharing clk/rst.
module tb_fp_compare_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fp_compare_pipe_if #(.FPWID(32), .TAGW(4)) bus32 ();
  fp_compare_pipe_if #(.FPWID(64), .TAGW(4)) bus64 ();

  fp_compare_pipe #(.FPWID(32), .TAGW(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  fp_compare_pipe #(.FPWID(64), .TAGW(4)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  // Issues one operation on the single-precision instance and returns the result and post-handshake flags.
  task automatic run_op(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic [3:0] tag_v, input logic clr,
                        output logic [15:0] o_v, output logic [31:0] res_v, output logic [3:0] tg_v,
                        output logic nan_v, output logic snan_v, output logic [1:0] flg_v,
                        output int lat);
    @(negedge clk);
    bus32.in_valid  = 1'b1;
    bus32.op        = op_v;
    bus32.a         = a_v;
    bus32.b         = b_v;
    bus32.tag_i     = tag_v;
    bus32.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    lat = 1;
    while (!bus32.out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    o_v    = bus32.o;
    res_v  = bus32.res;
    tg_v   = bus32.tag_o;
    nan_v  = bus32.nan;
    snan_v = bus32.snan;
    bus32.clr_flags = clr;
    @(posedge clk);
    @(negedge clk);
    flg_v = bus32.flags;
    bus32.clr_flags = 1'b0;
  endtask

  task automatic run_op64(input logic [1:0] op_v, input logic [63:0] a_v, input logic [63:0] b_v,
                          output logic [15:0] o_v, output logic [63:0] res_v, output logic nan_v,
                          output int lat);
    @(negedge clk);
    bus64.in_valid  = 1'b1;
    bus64.op        = op_v;
    bus64.a         = a_v;
    bus64.b         = b_v;
    bus64.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus64.in_valid = 1'b0;
    lat = 1;
    while (!bus64.out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    o_v   = bus64.o;
    res_v = bus64.res;
    nan_v = bus64.nan;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus32.out_valid); end
    total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", bus32.in_ready); end
    total++; if (bus32.flags !== 2'b00) begin bad++; $display("[TB] FAIL reset_flags got=%b want=00", bus32.flags); end
    total++; if (bus32.o !== 16'h0000) begin bad++; $display("[TB] FAIL reset_o got=%h want=0000", bus32.o); end
    total++; if (bus32.res !== 32'h0) begin bad++; $display("[TB] FAIL reset_res got=%h want=0", bus32.res); end
    total++; if (bus32.tag_o !== 4'h0) begin bad++; $display("[TB] FAIL reset_tag got=%h want=0", bus32.tag_o); end
    total++; if ({bus32.nan, bus32.snan} !== 2'b00) begin bad++; $display("[TB] FAIL reset_nan got=%b want=00", {bus32.nan, bus32.snan}); end
    total++; if (bus64.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset64_out_valid got=%b want=0", bus64.out_valid); end
  endtask

  task automatic test_compare();
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic [15:0] vo [9];
    logic [1:0]  vn [9];
    logic [15:0] o_v; logic [31:0] res_v; logic [3:0] tg; logic n, s; logic [1:0] f; int lat;
    va[0] = 32'h80000000; vb[0] = 32'h00000000; vo[0] = 16'h1A05; vn[0] = 2'b00;
    va[1] = 32'hBF800000; vb[1] = 32'h3F800000; vo[1] = 16'h1906; vn[1] = 2'b00;
    va[2] = 32'hC0000000; vb[2] = 32'hBF800000; vo[2] = 16'h1906; vn[2] = 2'b00;
    va[3] = 32'h3F800000; vb[3] = 32'h40000000; vo[3] = 16'h110E; vn[3] = 2'b00;
    va[4] = 32'h40000000; vb[4] = 32'h3F800000; vo[4] = 16'h1F00; vn[4] = 2'b00;
    va[5] = 32'h3F800000; vb[5] = 32'h3F800000; vo[5] = 16'h1A05; vn[5] = 2'b00;
    va[6] = 32'h7FC00000; vb[6] = 32'h3F800000; vo[6] = 16'h0F10; vn[6] = 2'b10;
    va[7] = 32'h3F800000; vb[7] = 32'h7F800001; vo[7] = 16'h0718; vn[7] = 2'b11;
    va[8] = 32'hFF800000; vb[8] = 32'h3F800000; vo[8] = 16'h1906; vn[8] = 2'b00;
    for (int i = 0; i < 9; i++) begin
      run_op(2'd0, va[i], vb[i], 4'(i), 1'b0, o_v, res_v, tg, n, s, f, lat);
      total++; if (o_v !== vo[i]) begin bad++; $display("[TB] FAIL cmp_mask[%0d] got=%h want=%h", i, o_v, vo[i]); end
      total++; if ({n, s} !== vn[i]) begin bad++; $display("[TB] FAIL cmp_nan[%0d] got=%b want=%b", i, {n, s}, vn[i]); end
      total++; if (res_v !== 32'h0) begin bad++; $display("[TB] FAIL cmp_res[%0d] got=%h want=0", i, res_v); end
      total++; if (tg !== 4'(i)) begin bad++; $display("[TB] FAIL cmp_tag[%0d] got=%h want=%h", i, tg, 4'(i)); end
      total++; if (lat !== 2) begin bad++; $display("[TB] FAIL cmp_latency[%0d] got=%0d want=2", i, lat); end
    end
  endtask

  task automatic test_minmax();
    logic [1:0]  vop [8];
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vr [8];
    logic [15:0] o_v; logic [31:0] res_v; logic [3:0] tg; logic n, s; logic [1:0] f; int lat;
    vop[0] = 2'd1; va[0] = 32'h3F800000; vb[0] = 32'h40000000; vr[0] = 32'h3F800000;
    vop[1] = 2'd2; va[1] = 32'hBF800000; vb[1] = 32'h3F800000; vr[1] = 32'h3F800000;
    vop[2] = 2'd1; va[2] = 32'h00000000; vb[2] = 32'h80000000; vr[2] = 32'h80000000;
    vop[3] = 2'd2; va[3] = 32'h80000000; vb[3] = 32'h00000000; vr[3] = 32'h00000000;
    vop[4] = 2'd2; va[4] = 32'h7FC00000; vb[4] = 32'h40000000; vr[4] = 32'h40000000;
    vop[5] = 2'd1; va[5] = 32'h7FC00000; vb[5] = 32'h7FA00000; vr[5] = 32'h7FC00000;
    vop[6] = 2'd3; va[6] = 32'h3F800000; vb[6] = 32'h40000000; vr[6] = 32'h00000000;
    vop[7] = 2'd1; va[7] = 32'hC0000000; vb[7] = 32'hBF800000; vr[7] = 32'hC0000000;
    for (int i = 0; i < 8; i++) begin
      run_op(vop[i], va[i], vb[i], 4'(i + 3), 1'b0, o_v, res_v, tg, n, s, f, lat);
      total++; if (res_v !== vr[i]) begin bad++; $display("[TB] FAIL minmax_res[%0d] got=%h want=%h", i, res_v, vr[i]); end
    end
    total++; if (o_v !== 16'h1906) begin bad++; $display("[TB] FAIL minmax_mask got=%h want=1906", o_v); end
  endtask

  task automatic test_flags();
    logic [15:0] o_v; logic [31:0] res_v; logic [3:0] tg; logic n, s; logic [1:0] f; int lat;
    run_op(2'd0, 32'h3F800000, 32'h40000000, 4'h1, 1'b1, o_v, res_v, tg, n, s, f, lat);
    total++; if (f !== 2'b00) begin bad++; $display("[TB] FAIL flags_clear_clean got=%b want=00", f); end
    run_op(2'd0, 32'h7FC00000, 32'h3F800000, 4'h2, 1'b0, o_v, res_v, tg, n, s, f, lat);
    total++; if (f !== 2'b01) begin bad++; $display("[TB] FAIL flags_qnan got=%b want=01", f); end
    run_op(2'd2, 32'h7FA00000, 32'h40000000, 4'h3, 1'b0, o_v, res_v, tg, n, s, f, lat);
    total++; if (res_v !== 32'h40000000) begin bad++; $display("[TB] FAIL snan_max_res got=%h want=40000000", res_v); end
    total++; if (s !== 1'b1) begin bad++; $display("[TB] FAIL snan_max_snan got=%b want=1", s); end
    total++; if (f !== 2'b11) begin bad++; $display("[TB] FAIL flags_snan got=%b want=11", f); end
    run_op(2'd0, 32'h7FC00000, 32'h3F800000, 4'h4, 1'b1, o_v, res_v, tg, n, s, f, lat);
    total++; if (f !== 2'b01) begin bad++; $display("[TB] FAIL flags_clear_set got=%b want=01", f); end
    @(negedge clk);
    bus32.clr_flags = 1'b1;
    @(negedge clk);
    bus32.clr_flags = 1'b0;
    total++; if (bus32.flags !== 2'b00) begin bad++; $display("[TB] FAIL flags_clear_idle got=%b want=00", bus32.flags); end
  endtask

  task automatic test_fp64();
    logic [15:0] o_v; logic [63:0] res_v; logic n; int lat;
    run_op64(2'd1, 64'h0000000000000000, 64'h8000000000000000, o_v, res_v, n, lat);
    total++; if (res_v !== 64'h8000000000000000) begin bad++; $display("[TB] FAIL fp64_min_zero got=%h want=8000000000000000", res_v); end
    total++; if (o_v !== 16'h1A05) begin bad++; $display("[TB] FAIL fp64_zero_mask got=%h want=1A05", o_v); end
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL fp64_latency got=%0d want=2", lat); end
    run_op64(2'd1, 64'h7FF8000000000001, 64'h7FF8000000000000, o_v, res_v, n, lat);
    total++; if (res_v !== 64'h7FF8000000000000) begin bad++; $display("[TB] FAIL fp64_qnan got=%h want=7FF8000000000000", res_v); end
    total++; if (n !== 1'b1) begin bad++; $display("[TB] FAIL fp64_nan got=%b want=1", n); end
    run_op64(2'd2, 64'h3FF0000000000000, 64'h4000000000000000, o_v, res_v, n, lat);
    total++; if (res_v !== 64'h4000000000000000) begin bad++; $display("[TB] FAIL fp64_max got=%h want=4000000000000000", res_v); end
  endtask

  // Streams 8 max(i, 0) operations; stall applies out_ready pattern 1,0,0,1.
  task automatic stream(input bit stall);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int bubbles = 0;
    bit held = 1'b0;
    logic [3:0] h_tag; logic [31:0] h_res; logic [15:0] h_o;
    while (got < 8 && cyc < 100) begin
      @(negedge clk);
      bus32.out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (sent < 8) begin
        bus32.in_valid = 1'b1;
        bus32.op       = 2'd2;
        bus32.a        = 32'(sent);
        bus32.b        = 32'h0;
        bus32.tag_i    = 4'(sent);
      end else begin
        bus32.in_valid = 1'b0;
      end
      #1;
      if (held) begin
        total++;
        if (!bus32.out_valid || bus32.tag_o !== h_tag || bus32.res !== h_res || bus32.o !== h_o) begin
          bad++;
          $display("[TB] FAIL stall_hold got=%b/%h/%h/%h want=1/%h/%h/%h", bus32.out_valid,
                   bus32.tag_o, bus32.res, bus32.o, h_tag, h_res, h_o);
        end
      end
      if (!stall && sent < 8 && !bus32.in_ready) bubbles++;
      if (bus32.out_valid && bus32.out_ready) begin
        total++;
        if (bus32.tag_o !== 4'(got) || bus32.res !== 32'(got)) begin
          bad++;
          $display("[TB] FAIL stream_order got=%h/%h want=%h/%h", bus32.tag_o, bus32.res, 4'(got), 32'(got));
        end
        got++;
      end
      held  = bus32.out_valid && !bus32.out_ready;
      h_tag = bus32.tag_o;
      h_res = bus32.res;
      h_o   = bus32.o;
      if (bus32.in_valid && bus32.in_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b1;
    #1;
    total++; if (got !== 8) begin bad++; $display("[TB] FAIL stream_count got=%0d want=8", got); end
    total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_extra got=%b want=0", bus32.out_valid); end
    if (!stall) begin
      total++; if (bubbles !== 0) begin bad++; $display("[TB] FAIL throughput_bubbles got=%0d want=0", bubbles); end
      total++; if (cyc !== 10) begin bad++; $display("[TB] FAIL throughput_cycles got=%0d want=10", cyc); end
    end
  endtask

  task automatic test_throughput();
    stream(1'b0);
  endtask

  task automatic test_back_to_back();
    stream(1'b1);
  endtask

  task automatic test_reset_midflight();
    logic [15:0] o_v; logic [31:0] res_v; logic [3:0] tg; logic n, s; logic [1:0] f; int lat;
    int ghosts = 0;
    run_op(2'd0, 32'h7FC00000, 32'h3F800000, 4'h5, 1'b0, o_v, res_v, tg, n, s, f, lat);
    total++; if (f !== 2'b01) begin bad++; $display("[TB] FAIL midflight_pre_flags got=%b want=01", f); end
    @(negedge clk);
    bus32.out_ready = 1'b0;
    bus32.in_valid  = 1'b1;
    bus32.op        = 2'd1;
    bus32.a         = 32'h3F800000;
    bus32.b         = 32'h40000000;
    bus32.tag_i     = 4'h9;
    @(negedge clk);
    bus32.tag_i = 4'hA;
    @(negedge clk);
    bus32.in_valid = 1'b0;
    #1;
    total++; if ({bus32.out_valid, bus32.in_ready} !== 2'b10) begin bad++; $display("[TB] FAIL midflight_full got=%b want=10", {bus32.out_valid, bus32.in_ready}); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midflight_out_valid got=%b want=0", bus32.out_valid); end
    total++; if (bus32.flags !== 2'b00) begin bad++; $display("[TB] FAIL midflight_flags got=%b want=00", bus32.flags); end
    total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midflight_in_ready got=%b want=1", bus32.in_ready); end
    bus32.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus32.out_valid) ghosts++;
    end
    total++; if (ghosts !== 0) begin bad++; $display("[TB] FAIL midflight_ghosts got=%0d want=0", ghosts); end
  endtask

  initial begin
    bus32.in_valid = 1'b0; bus32.op = 2'd0; bus32.a = '0; bus32.b = '0; bus32.tag_i = '0;
    bus32.out_ready = 1'b0; bus32.clr_flags = 1'b0;
    bus64.in_valid = 1'b0; bus64.op = 2'd0; bus64.a = '0; bus64.b = '0; bus64.tag_i = '0;
    bus64.out_ready = 1'b0; bus64.clr_flags = 1'b0;
    test_reset();
    test_compare();
    test_minmax();
    test_flags();
    test_fp64();
    test_throughput();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end
endmodule

// File: doc/fp_compare_pipe.md
FP_COMPARE_PIPE -- requirements
Module: fp_compare_pipe

Interface
REQ-001 SHALL have parameter FPWID, default 32, operand width; legal values 16, 32, 64, 128 (exponent/fraction 5/10, 8/23, 11/52, 15/112).
REQ-002 SHALL have parameter TAGW, default 4, width of the user tag carried alongside each operation.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands and op present.
REQ-006 SHALL have port in_ready  output  1  block accepts operation this cycle.
REQ-007 SHALL have port op  input  2  0=compare, 1=min, 2=max, 3=reserved (treated as compare).
REQ-008 SHALL have ports a, b  input  FPWID each  IEEE 754 operands.
REQ-009 SHALL have port tag_i  input  TAGW  user tag.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-012 SHALL have port o  output  16  compare mask.
REQ-013 SHALL have port res  output  FPWID  min/max result; zero for compare.
REQ-014 SHALL have port tag_o  output  TAGW  tag of the presented result.
REQ-015 SHALL have ports nan, snan  output  1 each  per-result NaN / signalling-NaN indication.
REQ-016 SHALL have port flags  output  2  sticky {invalid, unordered}; port clr_flags  input  1  clears flags.

Function
REQ-017 Mask layout SHALL be: o[0] eq, o[1] lt, o[2] lt|eq, o[3] magnitude-lt ({exp,frac} of a < b), o[4] unordered, o[8] ~eq, o[9] ~lt, o[10] ~(lt|eq), o[11] ~o[3], o[12] ~unordered, o[7:5] and o[15:13] zero.
REQ-018 eq SHALL be 1 only when ordered and (both operands zero of any sign, or a==b bitwise).
REQ-019 lt SHALL be: signs differ -> sa & !(both zero); both negative -> |a|>|b|; both positive -> |a|<|b|; lt SHALL be 0 when unordered.
REQ-020 NaN = exponent all ones and fraction nonzero; sNaN = NaN with fraction MSB 0; nan = either operand NaN; snan = either operand sNaN.
REQ-021 min/max SHALL treat -0 < +0; one NaN operand -> return other operand; both NaN -> canonical quiet NaN (sign 0, exp all ones, frac MSB 1, rest 0).
REQ-022 Pipeline SHALL have two register stages (S1 decode/magnitude compare, S2 result select); latency in_valid&in_ready to out_valid = 2 cycles when not stalled.
REQ-023 Pipeline SHALL advance when S2 empty or out_ready=1; in_ready = advance | !S1 valid, combinational; no accepted operation shall be lost or duplicated.
REQ-024 Sustained throughput SHALL be one operation per cycle with out_ready held high.
REQ-025 Results SHALL hold stable (o, res, tag_o, nan, snan) while out_valid=1 and out_ready=0.
REQ-026 flags SHALL update on the S2 output handshake: invalid |= snan | (nan & op==compare & lt-class query); for this block invalid |= snan only, unordered |= nan.
REQ-027 clr_flags coincident with a flag-setting handshake SHALL leave flags equal to that result's contribution (clear then set).
REQ-028 Outputs with out_valid=0 SHALL be don't-care except out_valid itself.

Reset
REQ-029 On rst=1 at a clock edge: S1/S2 valid bits, out_valid, flags SHALL be 0; o, res, tag_o, nan, snan SHALL be 0.
REQ-030 rst mid-operation SHALL discard all in-flight operations; in_ready SHALL be 1 in the cycle after reset deasserts.

Verification
REQ-031 FPWID=32, compare a=0x80000000 b=0x00000000 -> after 2 cycles o=0x1A05 (eq, le, mag-lt=0 -> o[11]=1, ~lt, ~unordered), nan=0.
REQ-032 FPWID=32, compare a=0xBF800000 (-1.0) b=0x3F800000 (1.0) -> o[1]=1, o[0]=0, o[2]=1, o[8]=1, o[12]=1.
REQ-033 FPWID=32, max a=0x7FA00000 (sNaN) b=0x40000000 -> res=0x40000000, snan=1, flags=2'b11.
REQ-034 FPWID=64, min a=+0 b=-0 -> res=0x8000000000000000; both qNaN -> res=0x7FF8000000000000.
REQ-035 Back-to-back 8 ops with tags 0..7, out_ready toggled 1,0,0,1... -> tag_o sequence 0..7 in order, no drop/duplicate, outputs stable during stall.
REQ-036 rst asserted with S1 and S2 full -> next cycle out_valid=0, flags=0, in_ready=1.
